// File: rtl/cic_interp_mc.sv
// Multi-channel CIC interpolator with a runtime ratio.
// The comb section runs at the input rate (phase-0 ticks) and the integrator
// section at the output rate (out_rate strobes). All channels share one
// phase counter, one holding register and one set of status flags. The
// output stage applies a rounding arithmetic shift, then saturates to OSZ bits.
//
// Input handshake: a sample set moves into the holding register on a rising
// clk edge where in_valid && in_ready. in_ready is simply !hold_full, so it
// does not depend on in_valid. in_data must stay stable while in_valid is
// high and in_ready is low. The holding register is emptied only by a
// phase-0 tick.
module cic_interp_mc #(
  parameter int NUM_STAGES = 3,
  parameter int ISZ        = 16,
  parameter int OSZ        = 16,
  parameter int NUM_CH     = 2,
  parameter int RLOG2_MAX  = 8,
  localparam int W  = ISZ + NUM_STAGES * RLOG2_MAX,
  localparam int SW = $clog2(W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    out_rate,
  input  logic [RLOG2_MAX:0]      ratio,
  input  logic [SW-1:0]           shift,
  input  logic [NUM_CH*ISZ-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*OSZ-1:0]   out_data,
  output logic                    out_valid,
  output logic                    underrun,
  output logic                    sat,
  input  logic                    clear_flags
);

  localparam logic [RLOG2_MAX:0] R_MIN = (RLOG2_MAX+1)'(2);
  localparam logic [RLOG2_MAX:0] R_MAX = (RLOG2_MAX+1)'(1) << RLOG2_MAX;
  localparam logic signed [W:0]  O_MAX = {{(W-OSZ+2){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [W:0]  O_MIN = {{(W-OSZ+2){1'b1}}, {(OSZ-1){1'b0}}};

  logic [RLOG2_MAX:0]   r_act;
  logic [RLOG2_MAX:0]   ratio_clamp;
  logic [RLOG2_MAX-1:0] phase;
  logic                 phase_wrap;
  logic                 tick;
  logic                 hold_full;
  logic [NUM_CH*ISZ-1:0] hold_data;
  logic                 hs;

  logic signed [W-1:0] diff      [NUM_CH][NUM_STAGES+1];
  logic signed [W-1:0] dly       [NUM_CH][NUM_STAGES];
  logic signed [W-1:0] integ     [NUM_CH][NUM_STAGES];
  logic signed [W-1:0] integ_nxt [NUM_CH][NUM_STAGES];

  logic signed [W:0]       round_add;
  logic signed [W:0]       ext_v [NUM_CH];
  logic signed [W:0]       rnd_v [NUM_CH];
  logic [NUM_CH*OSZ-1:0]   out_nxt;
  logic                    clip_any;

  // Ratios below 2 or above 2^RLOG2_MAX are pulled to the nearest legal value.
  assign ratio_clamp = (ratio < R_MIN) ? R_MIN :
                       (ratio > R_MAX) ? R_MAX : ratio;
  assign phase_wrap  = ({1'b0, phase} == (r_act - 1'b1));
  assign tick        = out_rate && (phase == '0);
  assign in_ready    = !hold_full;
  assign hs          = in_valid && in_ready;

  // Phase counter, ratio latch and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      r_act     <= ratio_clamp;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (out_rate) begin
        if (phase_wrap) begin
          phase <= '0;
          r_act <= ratio_clamp;
        end else begin
          phase <= phase + 1'b1;
        end
      end
      if (hs) begin
        hold_data <= in_data;
      end
      if (hs) begin
        hold_full <= 1'b1;
      end else if (tick) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Comb chain, advanced only on phase-0 ticks; an empty hold repeats the last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j <= NUM_STAGES; j++) diff[c][j] <= '0;
        for (int j = 0; j < NUM_STAGES; j++) dly[c][j] <= '0;
      end
    end else if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold_full) begin
          diff[c][0] <= {{(W-ISZ){hold_data[c*ISZ+ISZ-1]}}, hold_data[c*ISZ +: ISZ]};
        end
        dly[c][0] <= diff[c][0];
        for (int j = 1; j <= NUM_STAGES; j++) begin
          diff[c][j] <= diff[c][j-1] - dly[c][j-1];
        end
        for (int j = 1; j < NUM_STAGES; j++) begin
          dly[c][j] <= diff[c][j];
        end
      end
    end
  end

  // Next integrator values: stage 0 sees the comb output only on ticks (zero stuffing).
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NUM_STAGES; i++) integ_nxt[c][i] = '0;
      integ_nxt[c][0] = integ[c][0] + (tick ? diff[c][NUM_STAGES] : '0);
      for (int i = 1; i < NUM_STAGES; i++) begin
        integ_nxt[c][i] = integ[c][i] + integ[c][i-1];
      end
    end
  end

  // Integrator chain, advanced on every out_rate strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NUM_STAGES; i++) integ[c][i] <= '0;
      end
    end else if (out_rate) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NUM_STAGES; i++) integ[c][i] <= integ_nxt[c][i];
      end
    end
  end

  // Rounding shift and saturation of the freshly updated last integrator.
  always_comb begin
    out_nxt   = '0;
    clip_any  = 1'b0;
    round_add = '0;
    if (shift != '0) begin
      round_add = (W+1)'(1) << (shift - SW'(1));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ext_v[c] = {integ_nxt[c][NUM_STAGES-1][W-1], integ_nxt[c][NUM_STAGES-1]};
      rnd_v[c] = (ext_v[c] + round_add) >>> shift;
      if (rnd_v[c] > O_MAX) begin
        out_nxt[c*OSZ +: OSZ] = O_MAX[OSZ-1:0];
        clip_any = 1'b1;
      end else if (rnd_v[c] < O_MIN) begin
        out_nxt[c*OSZ +: OSZ] = O_MIN[OSZ-1:0];
        clip_any = 1'b1;
      end else begin
        out_nxt[c*OSZ +: OSZ] = rnd_v[c][OSZ-1:0];
      end
    end
  end

  // Output register, one-cycle valid pulse and sticky flags (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= out_rate;
      if (out_rate) begin
        out_data <= out_nxt;
      end
      underrun <= (underrun & ~clear_flags) | (tick & ~hold_full);
      sat      <= (sat & ~clear_flags) | (out_rate & clip_any);
    end
  end

endmodule
